// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - datapath widths (address, instruction, opcode)
//   - default conditional-branch opcode and predictor reset value
//   - bit positions of the ALU->fetch resolution bus and the fetch->CU bus
//   - sat_update(): 2-bit saturating counter step used by the predictor
package fetch_unit_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] BRANCH_OPCODE_DEFAULT = 4'b0110;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] BHT_RESET = 2'b01;

  // alu_fetch_interface field positions
  localparam int ALU_W           = 19;
  localparam int ALU_FLUSH_BIT   = 0;
  localparam int ALU_BR_ADDR_LSB = 1;
  localparam int ALU_NT_ADDR_LSB = 9;
  localparam int ALU_IS_COND_BIT = 17;
  localparam int ALU_TAKEN_BIT   = 18;

  // fetch_cu_interface field positions
  localparam int CU_W          = 50;
  localparam int CU_INSTR_LSB  = 0;
  localparam int CU_ALT_LSB    = 32;
  localparam int CU_PC_LSB     = 40;
  localparam int CU_PRED_BIT   = 48;
  localparam int CU_VALID_BIT  = 49;

  // One training step of a 2-bit counter; clamps at both ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11)
      res = ctr + 2'd1;
    else if (!taken && ctr != 2'b00)
      res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating branch predictor counters.
//   clk, rst      : clock, asynchronous active-high reset (all counters -> 01)
//   rd_idx/rd_ctr : combinational read port, returns the current counter value
//   train_*       : synchronous training port; when train_valid is high the
//                   entry at train_idx steps toward taken/not-taken at the edge
module branch_history_table
  import fetch_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             train_valid,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // Read sees the registered value, so a same-cycle train of the same entry
  // only becomes visible after the edge.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (train_valid)
      ctr_d[train_idx] = sat_update(ctr_q[train_idx], train_taken);
  end

  // NOTE: this array is flops, not RAM, so it can and must be reset: every
  // entry starts weak-NT rather than at an arbitrary power-up value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= BHT_RESET;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a 2-bit dynamic branch predictor.
//   clk, rst              : clock, asynchronous active-high reset
//   alu_fetch_interface   : branch resolution from the ALU
//                           {taken, is_cond, alt_addr[7:0], br_addr[7:0], flush}
//   instr_mem_in          : instruction word at instr_mem_address_out (same cycle)
//   stall_in              : hold PC and the output register
//   instr_mem_address_out : current PC
//   fetch_cu_interface    : registered {valid, prediction, pc, alternate, instruction}
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               BHT_ENTRIES   = 16,
  parameter logic [OPC_W-1:0] BRANCH_OPCODE = BRANCH_OPCODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALU_W-1:0]   alu_fetch_interface,
  input  logic [INSTR_W-1:0] instr_mem_in,
  input  logic               stall_in,
  output logic [ADDR_W-1:0]  instr_mem_address_out,
  output logic [CU_W-1:0]    fetch_cu_interface
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CU_W-1:0]   out_q, out_d;

  logic              flush;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] train_addr;
  logic              train_valid;
  logic              train_taken;

  logic [1:0]        bht_ctr;
  logic              is_branch;
  logic              pred_taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] alt_addr;

  assign flush         = alu_fetch_interface[ALU_FLUSH_BIT];
  assign redirect_addr = alu_fetch_interface[ALU_NT_ADDR_LSB +: ADDR_W];
  assign train_addr    = alu_fetch_interface[ALU_BR_ADDR_LSB +: ADDR_W];
  assign train_valid   = alu_fetch_interface[ALU_IS_COND_BIT];
  assign train_taken   = alu_fetch_interface[ALU_TAKEN_BIT];

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (pc_q[IDX_W-1:0]),
    .rd_ctr      (bht_ctr),
    .train_valid (train_valid),
    .train_idx   (train_addr[IDX_W-1:0]),
    .train_taken (train_taken)
  );

  // Prediction: only a branch with a taken-leaning counter leaves the
  // sequential path; the path not followed becomes the alternate address.
  // Non-branches carry PC+1 as alternate so the field is never stale.
  assign is_branch  = (instr_mem_in[INSTR_W-1 -: OPC_W] == BRANCH_OPCODE);
  assign target     = instr_mem_in[ADDR_W-1:0];
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign pred_taken = is_branch & bht_ctr[1];
  assign next_pc    = pred_taken ? target : pc_inc;
  assign alt_addr   = (is_branch && !pred_taken) ? target : pc_inc;

  // Priority flush > stall > normal. A flush wins even while stalled.
  // NOTE: pc_d/out_d default to their held values first, so every path
  // assigns them and no latch is inferred.
  always_comb begin
    pc_d  = pc_q;
    out_d = out_q;
    if (flush) begin
      pc_d  = redirect_addr;
      out_d = '0;
    end else if (!stall_in) begin
      pc_d                                = next_pc;
      out_d[CU_VALID_BIT]                 = 1'b1;
      out_d[CU_PRED_BIT]                  = pred_taken;
      out_d[CU_PC_LSB +: ADDR_W]          = pc_q;
      out_d[CU_ALT_LSB +: ADDR_W]         = alt_addr;
      out_d[CU_INSTR_LSB +: INSTR_W]      = instr_mem_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      out_q <= '0;
    end else begin
      pc_q  <= pc_d;
      out_q <= out_d;
    end
  end

  assign instr_mem_address_out = pc_q;
  assign fetch_cu_interface    = out_q;

endmodule
